// File: rtl/wmt_pkg.sv
// Shared helpers for the weighted trend detector.
// Width derivations, config address map, config FSM states.
package wmt_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic int aw_f(input int n);
    return clog2(n + 2);
  endfunction

  function automatic int sw_f(input int n, input int w);
    return w + clog2(n + 1);
  endfunction

  function automatic int addr_th_hi(input int n);
    return n;
  endfunction

  function automatic int addr_th_lo(input int n);
    return n + 1;
  endfunction

  function automatic int def_weight(input int n, input int k, input int w);
    int m;
    m = (1 << w) - 1;
    return ((n - k) < m) ? (n - k) : m;
  endfunction

  typedef enum logic {
    CFG_IDLE,
    CFG_APPLY
  } cfg_state_e;

endpackage

// File: rtl/wmt_weighted_sum.sv
// Masked adder over the sample window: adds weight[k] for every set tap.
// Purely combinational; the top registers the result.
module wmt_weighted_sum
  import wmt_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 4,
  parameter int SW    = 8
) (
  input  logic [N-1:0]     win_i,
  input  logic [WIDTH-1:0] wt_i [N],
  output logic [SW-1:0]    sum_o
);

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < N; k++) begin
      if (win_i[k]) sum_o = sum_o + SW'(wt_i[k]);
    end
  end

endmodule

// File: rtl/weighted_trend_detector.sv
// Pipelined weighted-majority trend detector with hysteresis thresholds.
// Define WMT_DEBOUNCE_EN to require DEB agreeing evaluations per flip.
module weighted_trend_detector
  import wmt_pkg::*;
#(
  parameter int N         = 8,
  parameter int WIDTH     = 4,
  parameter int DEF_TH_HI = 24,
  parameter int DEF_TH_LO = 12,
  parameter int DEB       = 2,
  localparam int AW = aw_f(N),
  localparam int SW = sw_f(N, WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_addr,
  input  logic [SW-1:0] cfg_data,
  output logic          cfg_err,
  output logic          trend,
  output logic          trend_valid,
  output logic          trend_change,
  output logic          warm,
  output logic [SW-1:0] sum_out
);

  localparam int FW = clog2(N + 1);

  logic [N-1:0]     win_q;
  logic [FW-1:0]    fill_q;
  logic [WIDTH-1:0] wt_q [N];
  logic [SW-1:0]    hi_q, lo_q, sum_q, sum_d;
  logic             e1_q, e2_q;
  logic             trend_q, tv_q, tc_q;
  logic             want_d, flip_d;
  cfg_state_e       st_q;
  logic             rdy_q, err_q;

  wmt_weighted_sum #(.N(N), .WIDTH(WIDTH), .SW(SW)) u_sum (
    .win_i (win_q),
    .wt_i  (wt_q),
    .sum_o (sum_d)
  );

  // e1/e2 tag samples that are accepted while warm or that make warm
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
      e1_q   <= 1'b0;
      e2_q   <= 1'b0;
      sum_q  <= '0;
    end else begin
      e1_q  <= in_valid && (fill_q >= FW'(N - 1));
      e2_q  <= e1_q;
      sum_q <= sum_d;
      if (in_valid) begin
        win_q <= {win_q[N-2:0], in_bit};
        if (fill_q != FW'(N)) fill_q <= fill_q + 1'b1;
      end
    end
  end

`ifdef WMT_DEBOUNCE_EN
  localparam int CW = (DEB > 1) ? clog2(DEB + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_deb;
  assign unused_deb = (DEB != 0);
`endif

  always_comb begin
    want_d = trend_q;
    if (sum_q >= hi_q) want_d = 1'b1;
    else if (sum_q < lo_q) want_d = 1'b0;
    flip_d = 1'b0;
`ifdef WMT_DEBOUNCE_EN
    cnt_d = cnt_q;
    if (e2_q) begin
      if (want_d != trend_q) begin
        if (int'(cnt_q) + 1 >= DEB) begin
          flip_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
`else
    flip_d = e2_q && (want_d != trend_q);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trend_q <= 1'b0;
      tv_q    <= 1'b0;
      tc_q    <= 1'b0;
`ifdef WMT_DEBOUNCE_EN
      cnt_q   <= '0;
`endif
    end else begin
      tv_q <= e2_q;
      tc_q <= flip_d;
      if (flip_d) trend_q <= ~trend_q;
`ifdef WMT_DEBOUNCE_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  // Config writes land at the edge ending the accept cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= CFG_IDLE;
      rdy_q <= 1'b1;
      err_q <= 1'b0;
      hi_q  <= SW'(DEF_TH_HI);
      lo_q  <= SW'(DEF_TH_LO);
      for (int k = 0; k < N; k++)
        wt_q[k] <= WIDTH'(def_weight(N, k, WIDTH));
    end else begin
      unique case (st_q)
        CFG_IDLE: begin
          err_q <= 1'b0;
          if (cfg_valid) begin
            st_q  <= CFG_APPLY;
            rdy_q <= 1'b0;
            unique case (1'b1)
              (cfg_addr < AW'(N)): begin
                for (int k = 0; k < N; k++)
                  if (cfg_addr == AW'(k))
                    wt_q[k] <= cfg_data[WIDTH-1:0];
              end
              (cfg_addr == AW'(addr_th_hi(N))): hi_q <= cfg_data;
              (cfg_addr == AW'(addr_th_lo(N))): lo_q <= cfg_data;
              default: err_q <= 1'b1;
            endcase
          end
        end
        CFG_APPLY: begin
          st_q  <= CFG_IDLE;
          rdy_q <= 1'b1;
          err_q <= 1'b0;
        end
        default: st_q <= CFG_IDLE;
      endcase
    end
  end

  assign cfg_ready    = rdy_q;
  assign cfg_err      = err_q;
  assign trend        = trend_q;
  assign trend_valid  = tv_q;
  assign trend_change = tc_q;
  assign warm         = (fill_q == FW'(N));
  assign sum_out      = sum_q;

endmodule

// File: tb/tb_weighted_trend_detector.sv
// Bench for weighted_trend_detector: directed steps plus random traffic
// against a cycle-level reference model of the window/sum/trend rules.
module tb_weighted_trend_detector;
  import wmt_pkg::*;

  localparam int N  = 8;
  localparam int W  = 4;
  localparam int AW = aw_f(N);
  localparam int SW = sw_f(N, W);
`ifdef WMT_DEBOUNCE_EN
  localparam int DEB = 2;
`endif

  logic          clk = 0;
  logic          reset;
  logic          in_valid, in_bit, cfg_valid;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_data;
  logic          cfg_ready, cfg_err, trend, trend_valid;
  logic          trend_change, warm;
  logic [SW-1:0] sum_out;

  weighted_trend_detector #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .trend(trend),
    .trend_valid(trend_valid), .trend_change(trend_change),
    .warm(warm), .sum_out(sum_out)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int n_chk = 0;

  // reference model: expected outputs for the current cycle
  int mwin [N];
  int mw [N];
  int mfill, mhi, mlo, m_e1, m_e2, mcnt;
  int x_sum, x_trend, x_tv, x_tc, x_rdy, x_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mwin[k] = 0;
      mw[k] = (N - k < 15) ? N - k : 15;
    end
    mfill = 0; mhi = 24; mlo = 12; m_e1 = 0; m_e2 = 0; mcnt = 0;
    x_sum = 0; x_trend = 0; x_tv = 0; x_tc = 0; x_rdy = 1; x_err = 0;
  endtask

  task automatic model_step(input int v, input int b, input int cv,
                            input int ca, input int cd);
    int s, want, flip, n_e1;
    s = 0;
    for (int k = 0; k < N; k++) if (mwin[k] != 0) s += mw[k];
    want = x_trend;
    if (x_sum >= mhi) want = 1;
    else if (x_sum < mlo) want = 0;
    flip = 0;
    if (m_e2 != 0) begin
`ifdef WMT_DEBOUNCE_EN
      if (want != x_trend) begin
        mcnt++;
        if (mcnt >= DEB) begin flip = 1; mcnt = 0; end
      end else mcnt = 0;
`else
      flip = (want != x_trend) ? 1 : 0;
`endif
    end
    x_tv = m_e2;
    x_tc = flip;
    if (flip != 0) x_trend = 1 - x_trend;
    m_e2 = m_e1;
    n_e1 = (v != 0 && mfill >= N - 1) ? 1 : 0;
    m_e1 = n_e1;
    x_sum = s;
    if (v != 0) begin
      for (int k = N - 1; k > 0; k--) mwin[k] = mwin[k-1];
      mwin[0] = b;
      if (mfill < N) mfill++;
    end
    if (cv != 0 && x_rdy != 0) begin
      x_rdy = 0;
      x_err = (ca > N + 1) ? 1 : 0;
      if (ca < N) mw[ca] = cd % 16;
      else if (ca == N) mhi = cd;
      else if (ca == N + 1) mlo = cd;
    end else begin
      x_rdy = 1;
      x_err = 0;
    end
  endtask

  task automatic check_all();
    chk("sum_out", 32'(sum_out), 32'(x_sum));
    chk("trend", 32'(trend), 32'(x_trend));
    chk("trend_valid", 32'(trend_valid), 32'(x_tv));
    chk("trend_change", 32'(trend_change), 32'(x_tc));
    chk("warm", 32'(warm), 32'(mfill == N));
    chk("cfg_ready", 32'(cfg_ready), 32'(x_rdy));
    chk("cfg_err", 32'(cfg_err), 32'(x_err));
  endtask

  task automatic cyc(input int v, input int b, input int cv = 0,
                     input int ca = 0, input int cd = 0);
    @(negedge clk);
    check_all();
    in_valid  = v[0];
    in_bit    = b[0];
    cfg_valid = cv[0];
    cfg_addr  = AW'(ca);
    cfg_data  = SW'(cd);
    model_step(v, b, cv, ca, cd);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_bit = 0;
    cfg_valid = 0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    cyc(0, 0);
    chk("reset_ready", 32'(cfg_ready), 32'd1);

    // defaults: eight ones then zeros
    for (int i = 0; i < 8; i++) cyc(1, 1);
    cyc(0, 0);
    chk("warm_rise", 32'(warm), 32'd1);
    cyc(0, 0);
    chk("sum36", 32'(sum_out), 32'd36);
    cyc(0, 0);
    chk("tv_36", 32'(trend_valid), 32'd1);
`ifndef WMT_DEBOUNCE_EN
    chk("trend_36", 32'(trend), 32'd1);
    chk("tc_36", 32'(trend_change), 32'd1);
`endif
    for (int i = 0; i < 4; i++) cyc(1, 0);
    repeat (4) cyc(0, 0);

    // reprogram weight 0 and th_hi, then a single one
    cyc(0, 0, 1, 0, 15);
    chk("ready_low", 32'(cfg_ready), 32'd1);
    cyc(0, 0);
    chk("apply_ready", 32'(cfg_ready), 32'd0);
    cyc(0, 0, 1, N, 15);
    cyc(0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0);
    cyc(1, 1);
    repeat (4) cyc(0, 0);

    // invalid address, then a write that must wait out APPLY
    cyc(0, 0, 1, 10, 3);
    cyc(0, 0, 1, N + 1, 5);
    chk("err_pulse", 32'(cfg_err), 32'd1);
    cyc(0, 0, 1, N + 1, 5);
    cyc(0, 0);
    chk("err_once", 32'(cfg_err), 32'd0);

    // saturate trend high, then async reset mid-stream
    for (int i = 0; i < 8; i++) cyc(1, 1);
    repeat (4) cyc(0, 0);
    chk("pre_reset_trend", 32'(trend), 32'd1);
    #2 reset = 1;
    #1;
    chk("rst_trend", 32'(trend), 32'd0);
    chk("rst_warm", 32'(warm), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) cyc(1, 1);
    cyc(0, 0);
    cyc(0, 0);
    chk("post_rst_sum36", 32'(sum_out), 32'd36);
    cyc(0, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int v, b, cv, ca, cd;
      v  = ($urandom % 4 != 0) ? 1 : 0;
      b  = $urandom % 2;
      cv = ($urandom % 8 == 0) ? 1 : 0;
      ca = $urandom_range(0, 11);
      cd = $urandom_range(0, 80);
      cyc(v, b, cv, ca, cd);
    end
    repeat (4) cyc(0, 0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
